mux_sweep_reporter: RTL and testbench

MUX_SWEEP_REPORTER -- requirements
Module: mux_sweep_reporter

---
 rtl/mux_sweep_reporter.sv | 131 +++++++++++++
 tb/tb_mux_sweep_reporter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mux_sweep_reporter.sv
// Drives all eight {sel,I1,I0} vectors into a mux pair, records which ones
// mismatch, then reports the fail mask and {4'h5, count} as two 8N1 bytes.
module mux_sweep_reporter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SETTLE       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       match,
  output logic       I0,
  output logic       I1,
  output logic       sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] fail_mask,
  output logic [3:0] mismatch_cnt,
  output logic       UART_TXD
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE, SWEEP, TX_START, TX_DATA, TX_STOP, FINISH
  } state_t;

  state_t          state, state_next;
  logic            start_q;
  logic [2:0]      v;
  logic [7:0]      settle_cnt;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic            byte_sel;
  logic [7:0]      tx_byte;

  logic start_edge, settle_last, baud_last, in_tx;
  assign start_edge  = start & ~start_q;
  assign settle_last = (settle_cnt == 8'(SETTLE - 1));
  assign baud_last   = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign in_tx       = (state == TX_START) || (state == TX_DATA) || (state == TX_STOP);
  assign tx_byte     = byte_sel ? {4'h5, mismatch_cnt} : fail_mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    UART_TXD   = 1'b1;
    I0         = 1'b0;
    I1         = 1'b0;
    sel        = 1'b0;
    case (state)
      IDLE: if (start_edge) state_next = SWEEP;
      SWEEP: begin
        busy           = 1'b1;
        {sel, I1, I0}  = v;
        if (settle_last && (v == 3'd7)) state_next = TX_START;
      end
      TX_START: begin
        busy     = 1'b1;
        UART_TXD = 1'b0;
        if (baud_last) state_next = TX_DATA;
      end
      TX_DATA: begin
        busy     = 1'b1;
        UART_TXD = tx_byte[bit_idx];
        if (baud_last && (bit_idx == 3'd7)) state_next = TX_STOP;
      end
      TX_STOP: begin
        busy = 1'b1;
        if (baud_last) state_next = byte_sel ? FINISH : TX_START;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sweep datapath: vector index, hold counter and mismatch bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q      <= 1'b0;
      v            <= 3'd0;
      settle_cnt   <= 8'd0;
      fail_mask    <= 8'd0;
      mismatch_cnt <= 4'd0;
    end else begin
      start_q <= start;
      if (state == IDLE && start_edge) begin
        v            <= 3'd0;
        settle_cnt   <= 8'd0;
        fail_mask    <= 8'd0;
        mismatch_cnt <= 4'd0;
      end else if (state == SWEEP) begin
        if (settle_last) begin
          settle_cnt <= 8'd0;
          v          <= v + 3'd1;
          if (!match) begin
            fail_mask[v] <= 1'b1;
            if (mismatch_cnt != 4'd8) mismatch_cnt <= mismatch_cnt + 4'd1;
          end
        end else begin
          settle_cnt <= settle_cnt + 8'd1;
        end
      end
    end
  end

  // Transmit datapath: baud timer, data bit index and which byte is on the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      byte_sel <= 1'b0;
    end else begin
      if (in_tx) baud_cnt <= baud_last ? '0 : baud_cnt + BW'(1);
      else       baud_cnt <= '0;
      if (state == TX_DATA && baud_last) bit_idx <= bit_idx + 3'd1;
      else if (!in_tx)                   bit_idx <= 3'd0;
      if (state == TX_STOP && baud_last) byte_sel <= 1'b1;
      else if (!in_tx)                   byte_sel <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_sweep_reporter.sv
// Directed sequence of randomized sweeps against a truth-table model of the
// mux comparator and a bit-level picture of the expected two-byte UART frame.
module tb_mux_sweep_reporter;

  localparam int CPB = 4;
  localparam int ST  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       match = 1'b0;
  logic       I0, I1, sel, busy, done, UART_TXD;
  logic [7:0] fail_mask;
  logic [3:0] mismatch_cnt;

  int total = 0;
  int bad   = 0;

  mux_sweep_reporter #(.CLKS_PER_BIT(CPB), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .start(start), .match(match),
    .I0(I0), .I1(I1), .sel(sel), .busy(busy), .done(done),
    .fail_mask(fail_mask), .mismatch_cnt(mismatch_cnt), .UART_TXD(UART_TXD)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_txd", 32'(UART_TXD), 32'd1);
      check("idle_done", 32'(done), 32'd0);
      tick();
    end
  endtask

  // good[v] = comparator result presented for vector v on its sampling cycle.
  task automatic run(input logic [7:0] good, input int inject_at, input int abort_at,
                     input bit hold_start);
    logic [7:0]  exp_fail;
    logic [3:0]  exp_cnt;
    logic [19:0] frame;
    int          vec;
    exp_fail = ~good;
    exp_cnt  = 4'd0;
    for (int i = 0; i < 8; i++) if (exp_fail[i]) exp_cnt = exp_cnt + 4'd1;
    frame = {1'b1, 4'h5, exp_cnt, 1'b0, 1'b1, exp_fail, 1'b0};

    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    for (int t = 0; t < 8 * ST; t++) begin
      vec = t / ST;
      check("sweep_busy", 32'(busy), 32'd1);
      check("sweep_vec", 32'({sel, I1, I0}), 32'(vec));
      check("sweep_txd", 32'(UART_TXD), 32'd1);
      match = ((t % ST) == ST - 1) ? good[vec] : 1'($urandom_range(0, 1));
      tick();
    end
    match = 1'b0;
    for (int t = 0; t < 20 * CPB; t++) begin
      if (t == abort_at) begin
        rst = 1'b0;
        #1;
        check("abort_txd", 32'(UART_TXD), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mask", 32'(fail_mask), 32'd0);
        check("abort_cnt", 32'(mismatch_cnt), 32'd0);
        return;
      end
      check("tx_txd", 32'(UART_TXD), 32'(frame[t / CPB]));
      check("tx_busy", 32'(busy), 32'd1);
      check("tx_done", 32'(done), 32'd0);
      check("tx_vec", 32'({sel, I1, I0}), 32'd0);
      if (t == inject_at)     start = 1'b1;
      if (t == inject_at + 2) start = 1'b0;
      tick();
    end
    check("fin_done", 32'(done), 32'd1);
    check("fin_busy", 32'(busy), 32'd0);
    check("fin_txd", 32'(UART_TXD), 32'd1);
    check("fin_mask", 32'(fail_mask), 32'(exp_fail));
    check("fin_cnt", 32'(mismatch_cnt), 32'(exp_cnt));
    tick();
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("hold_mask", 32'(fail_mask), 32'(exp_fail));
    check("hold_cnt", 32'(mismatch_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    check("rst_txd", 32'(UART_TXD), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_vec", 32'({sel, I1, I0}), 32'd0);
    check("rst_mask", 32'(fail_mask), 32'd0);
    check("rst_cnt", 32'(mismatch_cnt), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    idle(3);

    // All match, match = ~sel, none match.
    run(8'hFF, -10, -1, 1'b0);
    idle(2);
    run(8'h0F, -10, -1, 1'b0);
    idle(2);
    run(8'h00, -10, -1, 1'b0);
    idle(2);

    // Second start pulse during the data bits of byte 0 must be ignored.
    run(8'($urandom_range(0, 255)), 3 * CPB + 1, -1, 1'b0);
    idle(8);

    // Reset during data bit 3 of byte 0, then a clean fresh sweep.
    run(8'($urandom_range(0, 255)), -10, (1 + 3) * CPB + 1, 1'b0);
    tick();
    tick();
    check("in_rst_busy", 32'(busy), 32'd0);
    check("in_rst_txd", 32'(UART_TXD), 32'd1);
    rst = 1'b1;
    idle(3);
    run(8'($urandom_range(0, 255)), -10, -1, 1'b0);
    idle(2);

    // Start already high at reset release counts as exactly one edge.
    rst = 1'b0;
    start = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    run(8'($urandom_range(0, 255)), -10, -1, 1'b1);
    idle(15);
    start = 1'b0;
    tick();
    run(8'($urandom_range(0, 255)), -10, -1, 1'b0);
    idle(2);

    for (int k = 0; k < 3; k++) begin
      run(8'($urandom_range(0, 255)), -10, -1, 1'b0);
      idle(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
